// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the unified memory port between instruction fetch and load/store.
// One access in flight; steers byte lanes, extends load data, flags misalignment and timeouts.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_,
   // fetch requester
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_rdata,
   // load/store requester
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [31:0] ls_addr,
   input  logic [1:0]  ls_size,
   input  logic        ls_uns,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   output logic        err,
   // memory port
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

   localparam logic [1:0] SzByte = 2'b00;
   localparam logic [1:0] SzHalf = 2'b01;
   localparam logic [1:0] SzWord = 2'b10;
   localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

   state_e state_q, state_d;

   // Attributes of the granted access, held until its response
   logic       sel_ls_q, sel_ls_d;
   logic       last_ls_q, last_ls_d;
   logic [1:0] lane_q, lane_d;
   logic [1:0] size_q, size_d;
   logic       uns_q, uns_d;
   logic       we_q, we_d;
   logic [7:0] timer_q, timer_d;

   // Registered outputs
   logic        if_done_q, if_done_d;
   logic [31:0] if_rdata_q, if_rdata_d;
   logic        ls_done_q, ls_done_d;
   logic [31:0] ls_rdata_q, ls_rdata_d;
   logic        err_q, err_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   logic        grant_if, grant_ls, grant;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        misaligned;
   logic        busy_ack, busy_expire;

   function automatic logic [3:0] lane_be(logic [1:0] size, logic [1:0] a);
      case (size)
         SzByte:  return 4'b0001 << a;
         SzHalf:  return 4'b0011 << a;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(logic [1:0] size, logic [31:0] wdata);
      case (size)
         SzByte:  return {4{wdata[7:0]}};
         SzHalf:  return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

   function automatic logic [31:0] load_align(logic [1:0] size, logic [1:0] lane, logic uns,
                                              logic [31:0] word);
      logic [31:0] sh;
      sh = word >> {lane, 3'b000};
      case (size)
         SzByte:  return {{24{~uns & sh[7]}}, sh[7:0]};
         SzHalf:  return {{16{~uns & sh[15]}}, sh[15:0]};
         default: return word;
      endcase
   endfunction

   // Requests are only looked at in IDLE; on contention the side not served last wins
   always_comb begin
      grant_if = 1'b0;
      grant_ls = 1'b0;
      if (state_q == StIdle) begin
         if (if_req && ls_req) begin
            grant_ls = ~last_ls_q;
            grant_if = last_ls_q;
         end else begin
            grant_if = if_req;
            grant_ls = ls_req;
         end
      end
   end

   assign grant    = grant_if | grant_ls;
   assign req_addr = grant_ls ? ls_addr : if_addr;
   // A fetch is always a word access
   assign req_size = grant_ls ? ls_size : SzWord;

   always_comb begin
      case (req_size)
         SzByte:  misaligned = 1'b0;
         SzHalf:  misaligned = req_addr[0];
         SzWord:  misaligned = |req_addr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   assign busy_ack    = (state_q == StBusy) && mem_ack;
   assign busy_expire = (state_q == StBusy) && !mem_ack && (timer_q == TimerLast);

   // State register
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (grant) begin
               state_d = misaligned ? StResp : StBusy;
            end
         end
         StBusy: begin
            if (busy_ack || busy_expire) begin
               state_d = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output and datapath next-state logic
   always_comb begin
      sel_ls_d    = sel_ls_q;
      last_ls_d   = last_ls_q;
      lane_d      = lane_q;
      size_d      = size_q;
      uns_d       = uns_q;
      we_d        = we_q;
      timer_d     = timer_q;
      if_done_d   = 1'b0;
      if_rdata_d  = '0;
      ls_done_d   = 1'b0;
      ls_rdata_d  = '0;
      err_d       = 1'b0;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;

      case (state_q)
         StIdle: begin
            if (grant) begin
               sel_ls_d  = grant_ls;
               last_ls_d = grant_ls;
               lane_d    = req_addr[1:0];
               size_d    = req_size;
               uns_d     = grant_ls & ls_uns;
               we_d      = grant_ls & ls_we;
               timer_d   = '0;
               if (misaligned) begin
                  if_done_d = grant_if;
                  ls_done_d = grant_ls;
                  err_d     = 1'b1;
               end else begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = grant_ls & ls_we;
                  mem_addr_d  = {req_addr[31:2], 2'b00};
                  mem_be_d    = lane_be(req_size, req_addr[1:0]);
                  mem_wdata_d = (grant_ls && ls_we) ? lane_wdata(ls_size, ls_wdata) : '0;
               end
            end
         end
         StBusy: begin
            if (busy_ack) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (sel_ls_q) begin
                  ls_done_d  = 1'b1;
                  ls_rdata_d = we_q ? '0 : load_align(size_q, lane_q, uns_q, mem_rdata);
               end else begin
                  if_done_d  = 1'b1;
                  if_rdata_d = mem_rdata;
               end
            end else if (busy_expire) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if_done_d = ~sel_ls_q;
               ls_done_d = sel_ls_q;
               err_d     = 1'b1;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         sel_ls_q    <= 1'b0;
         last_ls_q   <= 1'b0;
         lane_q      <= '0;
         size_q      <= '0;
         uns_q       <= 1'b0;
         we_q        <= 1'b0;
         timer_q     <= '0;
         if_done_q   <= 1'b0;
         if_rdata_q  <= '0;
         ls_done_q   <= 1'b0;
         ls_rdata_q  <= '0;
         err_q       <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
      end else begin
         sel_ls_q    <= sel_ls_d;
         last_ls_q   <= last_ls_d;
         lane_q      <= lane_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
         we_q        <= we_d;
         timer_q     <= timer_d;
         if_done_q   <= if_done_d;
         if_rdata_q  <= if_rdata_d;
         ls_done_q   <= ls_done_d;
         ls_rdata_q  <= ls_rdata_d;
         err_q       <= err_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign if_done   = if_done_q;
   assign if_rdata  = if_rdata_q;
   assign ls_done   = ls_done_q;
   assign ls_rdata  = ls_rdata_q;
   assign err       = err_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_be    = mem_be_q;
   assign mem_wdata = mem_wdata_q;

endmodule
